// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains in reset, then releases them one
// at a time in index order; supports masked (parked) domains and a software re-reset.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_DOMAINS-1:0]         domain_mask,
  input  logic                           sw_req,
  output logic                           sw_ack,
  output logic [NUM_DOMAINS-1:0]         domain_rst,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_DOMAINS):0]   cur_stage
);

  localparam int                SW_W        = $clog2(NUM_DOMAINS) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SW_W-1:0]   STAGE_IDLE  = SW_W'(NUM_DOMAINS);
  localparam logic [SW_W-1:0]   STAGE_FINAL = SW_W'(NUM_DOMAINS - 1);

  generate
    if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_hold
      $error("reset_sequencer: HOLD_CYCLES must be in 1..2**CNT_W");
    end
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_domains
      $error("reset_sequencer: NUM_DOMAINS must be in 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STAGE,
    ST_DONE
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SW_W-1:0]        r_cur_stage;
  logic [NUM_DOMAINS-1:0] r_domain_rst;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_sw_ack;

  logic [NUM_DOMAINS-1:0] w_stage_sel;
  logic                   w_stage_masked;
  logic                   w_cnt_last;
  logic                   w_skip;
  logic                   w_final_stage;

  // One-hot decode of the current stage, used both for mask lookup and release.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_sel
      assign w_stage_sel[gi] = (r_cur_stage == SW_W'(gi));
    end
  endgenerate

  // A masked stage is only recognised on its first cycle, so later mask edits are ignored.
  assign w_stage_masked = |(w_stage_sel & domain_mask);
  assign w_cnt_last     = (r_cnt == CNT_LAST);
  assign w_skip         = (r_cnt == '0) && w_stage_masked;
  assign w_final_stage  = (r_cur_stage == STAGE_FINAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ASSERT;
      r_cnt        <= '0;
      r_cur_stage  <= STAGE_IDLE;
      r_domain_rst <= '1;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_sw_ack     <= 1'b0;
    end else begin
      r_sw_ack <= 1'b0;
      case (r_state)
        ST_ASSERT: begin
          if (w_cnt_last) begin
            r_state     <= ST_STAGE;
            r_cnt       <= '0;
            r_cur_stage <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STAGE: begin
          if (w_skip || w_cnt_last) begin
            if (!w_skip) begin
              r_domain_rst <= r_domain_rst & ~w_stage_sel;
            end
            r_cnt <= '0;
            if (w_final_stage) begin
              r_state     <= ST_DONE;
              r_cur_stage <= STAGE_IDLE;
            end else begin
              r_cur_stage <= r_cur_stage + SW_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (sw_req) begin
            r_state      <= ST_ASSERT;
            r_cnt        <= '0;
            r_domain_rst <= '1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_sw_ack     <= 1'b1;
          end else begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_ASSERT;
        end
      endcase
    end
  end

  assign sw_ack     = r_sw_ack;
  assign domain_rst = r_domain_rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cur_stage  = r_cur_stage;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Staged reset controller for blocks built from asynchronously reset registers.
- Holds every reset domain in reset for a fixed interval, then releases the domains one at a time, in index order, with a programmable gap between releases.
- Supports a software-requested full re-reset, and a per-domain mask that keeps a domain parked in reset.
- Each `domain_rst` bit is a glitch-free flop output, safe to drive async `rst` pins directly.

Parameters:
- NUM_DOMAINS, 4: number of reset domains sequenced (1..16).
- HOLD_CYCLES, 16: cycles per assert phase and per unmasked stage (1..2^CNT_W).
- CNT_W, 8: width of the internal interval counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- domain_mask  input  NUM_DOMAINS  1 = domain is never released (stays in reset).
- sw_req  input  1  request a full re-reset sequence; honoured only in DONE.
- sw_ack  output  1  one-cycle pulse when `sw_req` is accepted.
- domain_rst  output  NUM_DOMAINS  per-domain reset, active-high, registered.
- busy  output  1  sequence in progress.
- done  output  1  all unmasked domains released.
- cur_stage  output  clog2(NUM_DOMAINS)+1  stage index; NUM_DOMAINS in ASSERT/DONE.

Behaviour:
- Reset values (`rst` high at an edge): `domain_rst` all 1s; `busy` = 1; `done` = 0; `sw_ack` = 0; `cur_stage` = NUM_DOMAINS; state = ASSERT; counter = 0.
- Edge numbering: edge 1 is the first rising edge at which `rst` is sampled low.
- State ASSERT:
  - Lasts exactly HOLD_CYCLES cycles (edges 1..H).
  - Counter increments each cycle; all domains stay asserted.
  - Moves to STAGE with stage = 0.
- State STAGE k:
  - `domain_mask[k]` is sampled on the stage's first cycle.
  - Unmasked: lasts HOLD_CYCLES cycles. `domain_rst[k]` falls on the last edge of the stage.
  - Masked: lasts 1 cycle. `domain_rst[k]` stays 1.
  - Mask changes after that first cycle are ignored for the rest of the sequence.
  - After stage NUM_DOMAINS-1, go to DONE.
- State DONE:
  - `done` = 1, `busy` = 0.
  - Released domains stay released; masked domains stay in reset.
- Counter:
  - Counts 0..H-1, then wraps to 0 at every phase end.
  - No overflow is possible when HOLD_CYCLES ≤ 2^CNT_W.
  - An out-of-range HOLD_CYCLES is a configuration error; flag it with an elaboration-time check.
- Software re-reset:
  - `sw_req` sampled high in DONE. On that same edge:
    - `domain_rst` goes to all 1s, `done` = 0, `busy` = 1, `sw_ack` = 1, state = ASSERT.
  - `sw_ack` is high for exactly one cycle.
  - The edge after acceptance counts as edge 1 of the new sequence.
- `sw_req` while busy: ignored, no `sw_ack`, no queuing.
- Holding `sw_req` high continuously: re-accepted each time DONE is reached, one `sw_ack` per sequence.
- `rst` mid-sequence: immediate restart from reset values; any domains already released are re-asserted on that edge.
- `rst` and `sw_req` high together: `rst` wins, no `sw_ack`.
- No output is combinational from any input; all outputs change only on `clk` edges.

Test Plan:
- NUM_DOMAINS=4, H=16, mask=0000, `rst` 3 cycles then low:
  - `domain_rst` = 1111 through edge 31.
  - Bits fall at edges 32, 48, 64, 80.
  - `done` rises at edge 81 with `busy` = 0.
- mask=0010, H=16:
  - d0 falls at 32, d2 at 49, d3 at 65.
  - d1 stays 1; `done` at 66.
- `sw_req` pulsed in DONE:
  - Same edge: `domain_rst` = 1111, `sw_ack` = 1 for 1 cycle, `busy` = 1.
  - d0 falls 32 edges later.
- `sw_req` held high from edge 40 (busy): no `sw_ack` until DONE; exactly one `sw_ack` at the first DONE cycle.
- `rst` asserted at edge 55, when d0 and d1 are already released: next value 1111; sequence replays from edge 1 timing.
- H=1, NUM_DOMAINS=1, mask=1:
  - ASSERT 1 cycle, masked stage 1 cycle.
  - `done` after edge 3; `domain_rst` stays 1.
